// File: rtl/alu_seq_pkg.sv
// Shared opcodes, instruction field positions and FSM state encoding for the ALU sequencer.
package alu_seq_pkg;

  localparam logic [31:0] PC_RESET    = 32'h0;
  localparam logic [5:0]  HALT_OPCODE = 6'd63;

  localparam logic [5:0] OP_ADD    = 6'd0;
  localparam logic [5:0] OP_SUB    = 6'd1;
  localparam logic [5:0] OP_SHL    = 6'd2;
  localparam logic [5:0] OP_SHR    = 6'd3;
  localparam logic [5:0] OP_LOAD   = 6'd5;
  localparam logic [5:0] OP_REG_HI = 6'd7;
  localparam logic [5:0] OP_CMP_LO = 6'd8;
  localparam logic [5:0] OP_CMP_HI = 6'd10;
  localparam logic [5:0] OP_F2_LO  = 6'd11;
  localparam logic [5:0] OP_F2_HI  = 6'd13;
  localparam logic [5:0] OP_JMP    = 6'd14;
  localparam logic [5:0] OP_JCOND  = 6'd15;
  localparam logic [5:0] OP_NOP    = 6'd62;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 23;
  localparam int RS_MSB  = 22;
  localparam int RS_LSB  = 20;
  localparam int HL_BIT  = 16;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Memory, register-file and ALU signals of the sequencer; master = sequencer, slave = core side.
interface alu_seq_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  logic [2:0]  rf_ra;
  logic [2:0]  rf_rb;
  logic [2:0]  rf_wa;
  logic        rf_we;
  logic [31:0] rf_wdata;

  logic [5:0]  alu_instr;
  logic [15:0] alu_value;
  logic        alu_highlow;
  logic        alu_f1;
  logic        alu_f2;
  logic [31:0] alu_c;
  logic        alu_f3;
  logic        alu_addrch;
  logic [31:0] alu_naddr;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output rf_ra, rf_rb, rf_wa, rf_we, rf_wdata,
    output alu_instr, alu_value, alu_highlow, alu_f1, alu_f2,
    input  alu_c, alu_f3, alu_addrch, alu_naddr
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  rf_ra, rf_rb, rf_wa, rf_we, rf_wdata,
    input  alu_instr, alu_value, alu_highlow, alu_f1, alu_f2,
    output alu_c, alu_f3, alu_addrch, alu_naddr
  );

endinterface

// File: rtl/alu_seq_decode.sv
// Opcode classifier: which writeback target an instruction uses, and whether it halts.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic       wb_reg_o,
  output logic       wb_f1_o,
  output logic       wb_f2_o,
  output logic       is_halt_o
);

  // Jumps (14, 15) and 16..62 fall through every range and write nothing.
  assign wb_reg_o  = (opcode_i <= OP_REG_HI);
  assign wb_f1_o   = (opcode_i >= OP_CMP_LO) && (opcode_i <= OP_CMP_HI);
  assign wb_f2_o   = (opcode_i >= OP_F2_LO) && (opcode_i <= OP_F2_HI);
  assign is_halt_o = (opcode_i == HALT_OPCODE);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer driving the ALU and register file.
// Optional build macro ALU_SEQ_PERF_EN adds the retired / stall_cycles counters.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | imem_req high until imem_ack, instruction latched on ack
// DECODE | fields presented to register file and ALU
// EXEC   | ALU results captured
// WB     | register/flag write, PC update
// HALT   | stopped, left only by reset
module alu_seq_ctrl
  import alu_seq_pkg::*;
(
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  output logic         busy,
  output logic         halted,
  output logic [31:0]  pc,
`ifdef ALU_SEQ_PERF_EN
  output logic [31:0]  retired,
  output logic [31:0]  stall_cycles,
`endif
  alu_seq_ctrl_if.master bus
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] c_q, c_d;
  logic [31:0] naddr_q, naddr_d;
  logic        f3_q, f3_d;
  logic        addrch_q, addrch_d;
  logic        f1_q, f1_d;
  logic        f2_q, f2_d;

  logic [5:0]  opcode;
  logic        wb_reg, wb_f1, wb_f2, is_halt;
  logic        unused_ir_bits;

  assign opcode         = ir_q[OP_MSB:OP_LSB];
  assign unused_ir_bits = ^ir_q[19:17];

  alu_seq_decode u_decode (
    .opcode_i  (opcode),
    .wb_reg_o  (wb_reg),
    .wb_f1_o   (wb_f1),
    .wb_f2_o   (wb_f2),
    .is_halt_o (is_halt)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_FETCH;
      ST_FETCH:  if (bus.imem_ack) state_d = ST_DECODE;
      ST_DECODE: state_d = is_halt ? ST_HALT : ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != ST_IDLE) && (state_q != ST_HALT);
    halted        = (state_q == ST_HALT);
    bus.imem_req  = (state_q == ST_FETCH);
    bus.rf_we     = (state_q == ST_WB) && wb_reg;
    bus.alu_instr = OP_NOP;
    if ((state_q == ST_DECODE) || (state_q == ST_EXEC) || (state_q == ST_WB))
      bus.alu_instr = opcode;
  end

  always_comb begin
    pc_d     = pc_q;
    ir_d     = ir_q;
    c_d      = c_q;
    naddr_d  = naddr_q;
    f3_d     = f3_q;
    addrch_d = addrch_q;
    f1_d     = f1_q;
    f2_d     = f2_q;
    if ((state_q == ST_FETCH) && bus.imem_ack)
      ir_d = bus.imem_rdata;
    if (state_q == ST_EXEC) begin
      c_d      = bus.alu_c;
      naddr_d  = bus.alu_naddr;
      f3_d     = bus.alu_f3;
      addrch_d = bus.alu_addrch;
    end
    if (state_q == ST_WB) begin
      pc_d = addrch_q ? naddr_q : (pc_q + 32'd1);
      if (wb_f1) f1_d = f3_q;
      if (wb_f2) f2_d = f3_q;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q     <= PC_RESET;
      ir_q     <= '0;
      c_q      <= '0;
      naddr_q  <= '0;
      f3_q     <= 1'b0;
      addrch_q <= 1'b0;
      f1_q     <= 1'b0;
      f2_q     <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      c_q      <= c_d;
      naddr_q  <= naddr_d;
      f3_q     <= f3_d;
      addrch_q <= addrch_d;
      f1_q     <= f1_d;
      f2_q     <= f2_d;
    end
  end

  assign pc              = pc_q;
  assign bus.imem_addr   = pc_q;
  assign bus.rf_ra       = ir_q[RD_MSB:RD_LSB];
  assign bus.rf_rb       = ir_q[RS_MSB:RS_LSB];
  assign bus.rf_wa       = ir_q[RD_MSB:RD_LSB];
  assign bus.rf_wdata    = c_q;
  assign bus.alu_value   = ir_q[IMM_MSB:IMM_LSB];
  assign bus.alu_highlow = ir_q[HL_BIT];
  assign bus.alu_f1      = f1_q;
  assign bus.alu_f2      = f2_q;

`ifdef ALU_SEQ_PERF_EN
  logic [31:0] retired_q, retired_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    retired_d = retired_q;
    stall_d   = stall_q;
    if (state_q == ST_WB) retired_d = retired_q + 32'd1;
    if ((state_q == ST_FETCH) && !bus.imem_ack) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
      stall_q   <= '0;
    end else begin
      retired_q <= retired_d;
      stall_q   <= stall_d;
    end
  end

  assign retired      = retired_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed testbench for alu_seq_ctrl; inputs change and outputs are sampled on the falling edge.
module tb_alu_seq_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        busy;
  logic        halted;
  logic [31:0] pc;
`ifdef ALU_SEQ_PERF_EN
  logic [31:0] retired;
  logic [31:0] stall_cycles;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  alu_seq_ctrl_if bus ();

  alu_seq_ctrl dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .start        (start),
    .busy         (busy),
    .halted       (halted),
    .pc           (pc),
`ifdef ALU_SEQ_PERF_EN
    .retired      (retired),
    .stall_cycles (stall_cycles),
`endif
    .bus          (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered on a falling edge while the DUT is in FETCH; returns on the falling edge of the next FETCH.
  task automatic run_instr(input logic [31:0] word, input logic [31:0] c, input logic f3,
                           input logic ach, input logic [31:0] naddr, input int waits,
                           input logic [31:0] exp_addr, input logic exp_we,
                           input logic [2:0] exp_wa, input logic [31:0] exp_wd,
                           input logic exp_f1, input logic exp_f2);
    chk("fetch_req", bus.imem_req, 1);
    chk("fetch_addr", bus.imem_addr, exp_addr);
    chk("fetch_pc", pc, exp_addr);
    chk("fetch_busy", busy, 1);
    for (int i = 0; i < waits; i++) begin
      bus.imem_ack = 1'b0;
      @(negedge clock);
      chk("wait_req", bus.imem_req, 1);
      chk("wait_addr", bus.imem_addr, exp_addr);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clock);
    // ack left high with junk data outside FETCH must not disturb the latched word
    bus.imem_rdata = 32'hFFFF_FFFF;
    chk("dec_req", bus.imem_req, 0);
    chk("dec_instr", bus.alu_instr, {26'd0, word[31:26]});
    chk("dec_ra", bus.rf_ra, word[25:23]);
    chk("dec_rb", bus.rf_rb, word[22:20]);
    chk("dec_value", bus.alu_value, word[15:0]);
    chk("dec_highlow", bus.alu_highlow, word[16]);
    chk("dec_f1", bus.alu_f1, exp_f1);
    chk("dec_f2", bus.alu_f2, exp_f2);
    chk("dec_we", bus.rf_we, 0);
    bus.alu_c      = c;
    bus.alu_f3     = f3;
    bus.alu_addrch = ach;
    bus.alu_naddr  = naddr;
    @(negedge clock);
    chk("exec_we", bus.rf_we, 0);
    chk("exec_instr", bus.alu_instr, {26'd0, word[31:26]});
    @(negedge clock);
    bus.imem_ack   = 1'b0;
    bus.alu_c      = ~c;
    bus.alu_f3     = ~f3;
    bus.alu_addrch = ~ach;
    bus.alu_naddr  = ~naddr;
    chk("wb_req", bus.imem_req, 0);
    chk("wb_we", bus.rf_we, exp_we);
    if (exp_we) begin
      chk("wb_wa", bus.rf_wa, exp_wa);
      chk("wb_wdata", bus.rf_wdata, exp_wd);
    end
    @(negedge clock);
  endtask

  initial begin
    reset_n         = 1'b0;
    start           = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.alu_c       = 32'h0;
    bus.alu_f3      = 1'b0;
    bus.alu_addrch  = 1'b0;
    bus.alu_naddr   = 32'h0;

    repeat (2) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_we", bus.rf_we, 0);
    chk("rst_instr", bus.alu_instr, 62);
    chk("rst_pc", pc, 32'h0);
    chk("rst_f1", bus.alu_f1, 0);
    chk("rst_f2", bus.alu_f2, 0);

    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_req", bus.imem_req, 0);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;

    // ADD r1 <- 5
    run_instr(32'h0088_0000, 32'h5, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b1, 3'd1, 32'h5, 1'b0, 1'b0);
    // CMP (opcode 9) sets F1; rd=2 rs=3 highlow=1 imm=BEEF
    run_instr(32'h2531_BEEF, 32'h0, 1'b1, 1'b0, 32'h0, 0, 32'h1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    // JMP to 0x40
    run_instr(32'h3800_0000, 32'h0, 1'b0, 1'b1, 32'h40, 0, 32'h2, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    // opcode 12 sets F2, three wait states
    run_instr(32'h3000_0000, 32'h0, 1'b1, 1'b0, 32'h0, 3, 32'h40, 1'b0, 3'd0, 32'h0, 1'b1, 1'b0);
    // JCOND to 0xFFFFFFFF
    run_instr(32'h3C00_0000, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, 32'h41, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    // SUB r7 at the top address, PC wraps to 0
    run_instr(32'h0780_0000, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1, 32'hFFFF_FFFF, 1'b1, 3'd7, 32'hDEAD_BEEF, 1'b1, 1'b1);
    // opcode 8 clears F1
    run_instr(32'h2000_0000, 32'h0, 1'b0, 1'b0, 32'h0, 0, 32'h0, 1'b0, 3'd0, 32'h0, 1'b1, 1'b1);
    // opcode 20 writes nothing
    run_instr(32'h5000_0000, 32'h123, 1'b1, 1'b0, 32'h0, 0, 32'h1, 1'b0, 3'd0, 32'h0, 1'b0, 1'b1);
    chk("after_seq_pc", pc, 32'h2);

    // Reset in the middle of a FETCH wait
    bus.imem_ack = 1'b0;
    @(negedge clock);
    chk("mid_fetch_req", bus.imem_req, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_req", bus.imem_req, 0);
    chk("abort_pc", pc, 32'h0);
    chk("abort_f2", bus.alu_f2, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_abort_req", bus.imem_req, 0);
    chk("post_abort_busy", busy, 0);

    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("halt_fetch_req", bus.imem_req, 1);
    chk("halt_fetch_addr", bus.imem_addr, 32'h0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hFC00_0000;
    @(negedge clock);
    bus.imem_ack = 1'b0;
    chk("halt_dec_instr", bus.alu_instr, 63);
    chk("halt_dec_busy", busy, 1);
    @(negedge clock);
    chk("halt_halted", halted, 1);
    chk("halt_busy", busy, 0);
    chk("halt_req", bus.imem_req, 0);
    chk("halt_instr", bus.alu_instr, 62);
    chk("halt_we", bus.rf_we, 0);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      chk("halt_start_req", bus.imem_req, 0);
      chk("halt_start_halted", halted, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
